// File: rtl/id_ex_pipe_pkg.sv
// Shared constants for the ID/EX pipeline register: redirect bit positions,
// the operand-hold FSM encoding and the control fields of a bubble.
package id_ex_pipe_pkg;

    // Bit positions inside redirect1/redirect2/load_redirect.
    localparam int RS1_BIT = 0;
    localparam int RS2_BIT = 1;

    // RUN: operands come from the live forward mux.
    // HOLD: operands captured at stall entry are replayed.
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Control fields of an empty EX slot.
    localparam logic       BUBBLE_VALID   = 1'b0;
    localparam logic       BUBBLE_WE      = 1'b0;
    localparam logic       BUBBLE_LOAD    = 1'b0;
    localparam logic [4:0] BUBBLE_RD_ADDR = 5'd0;

    // Packed as {valid, we, load, rd_addr}.
    localparam logic [7:0] BUBBLE_CTRL = {BUBBLE_VALID, BUBBLE_WE, BUBBLE_LOAD, BUBBLE_RD_ADDR};

endpackage

// File: rtl/id_ex_pipe_dffec.sv
// Enable/clear D flip-flop bank with asynchronous active-low reset.
// Clear has priority over enable; reset forces all zeros.
module id_ex_pipe_dffec #(
    parameter int         W       = 1,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Register bank: reset > clear > enable > hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (clr_i) begin
            q_q <= CLR_VAL;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/id_ex_pipe_fwd_mux.sv
// Per-operand forwarding priority mux:
// load data at WB > one-cycle forward > two-cycle forward > register-file value.
// Register x0 is hardwired, so it never takes a forwarded value.
module id_ex_pipe_fwd_mux #(
    parameter int XLEN = 64
) (
    input  logic [4:0]      rs_addr_i,
    input  logic [XLEN-1:0] raw_i,
    input  logic            load_sel_i,
    input  logic            sel1_i,
    input  logic            sel2_i,
    input  logic [XLEN-1:0] load_data_i,
    input  logic [XLEN-1:0] m_data_i,
    input  logic [XLEN-1:0] w_data_i,
    output logic [XLEN-1:0] op_o
);

    // Priority select with the x0 guard in front of every forward source.
    always_comb begin
        op_o = raw_i;
        if (rs_addr_i != 5'd0) begin
            if (load_sel_i) begin
                op_o = load_data_i;
            end else if (sel1_i) begin
                op_o = m_data_i;
            end else if (sel2_i) begin
                op_o = w_data_i;
            end
        end
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with EX-side operand forwarding. Obeys the hazard
// controller's stall/flush, applies its redirect selects, and keeps the
// operands seen at stall entry so forwarded values survive a load-use freeze.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int PC_W  = 64,
    parameter int OP_W  = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_d,
    input  logic [PC_W-1:0]  pc_d,
    input  logic [OP_W-1:0]  op_d,
    input  logic [XLEN-1:0]  imm_d,
    input  logic [XLEN-1:0]  rs1_data_d,
    input  logic [XLEN-1:0]  rs2_data_d,
    input  logic [4:0]       rs1_addr_d,
    input  logic [4:0]       rs2_addr_d,
    input  logic [4:0]       rd_addr_d,
    input  logic             rd_we_d,
    input  logic             load_d,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic [1:0]       redirect1,
    input  logic [1:0]       redirect2,
    input  logic [1:0]       load_redirect,
    input  logic [XLEN-1:0]  fwd_m_data,
    input  logic [XLEN-1:0]  fwd_w_data,
    input  logic [XLEN-1:0]  load_w_data,
    output logic             valid_e,
    output logic [PC_W-1:0]  pc_e,
    output logic [OP_W-1:0]  op_e,
    output logic [XLEN-1:0]  imm_e,
    output logic [XLEN-1:0]  op1_e,
    output logic [XLEN-1:0]  op2_e,
    output logic [4:0]       rd_addr_e,
    output logic             rd_we_e,
    output logic             load_e,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam int DW = PC_W + OP_W + 3 * XLEN + 10;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [7:0]      ctrl_q;
    logic [DW-1:0]   data_q;
    logic [XLEN-1:0] rs1_data_e;
    logic [XLEN-1:0] rs2_data_e;
    logic [4:0]      rs1_addr_e;
    logic [4:0]      rs2_addr_e;
    logic [XLEN-1:0] mux1;
    logic [XLEN-1:0] mux2;

    state_e          state_q, state_d;
    logic [1:0]      hold_vld_q, hold_vld_d;
    logic [XLEN-1:0] hold_op1_q, hold_op1_d;
    logic [XLEN-1:0] hold_op2_q, hold_op2_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Control fields become a bubble on flush or when ID has nothing valid;
    // a stall without flush freezes them.
    id_ex_pipe_dffec #(
        .W       (8),
        .CLR_VAL (BUBBLE_CTRL)
    ) u_ctrl_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (!stall_e),
        .clr_i (flush_e || (!stall_e && !valid_d)),
        .d_i   ({valid_d, rd_we_d, load_d, rd_addr_d}),
        .q_o   (ctrl_q)
    );

    // Data fields load on flush as well (their contents are don't-care then).
    id_ex_pipe_dffec #(
        .W (DW)
    ) u_data_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (flush_e || !stall_e),
        .clr_i (1'b0),
        .d_i   ({pc_d, op_d, imm_d, rs1_data_d, rs2_data_d, rs1_addr_d, rs2_addr_d}),
        .q_o   (data_q)
    );

    assign {valid_e, rd_we_e, load_e, rd_addr_e} = ctrl_q;
    assign {pc_e, op_e, imm_e, rs1_data_e, rs2_data_e, rs1_addr_e, rs2_addr_e} = data_q;

    id_ex_pipe_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_addr_i   (rs1_addr_e),
        .raw_i       (rs1_data_e),
        .load_sel_i  (load_redirect[RS1_BIT]),
        .sel1_i      (redirect1[RS1_BIT]),
        .sel2_i      (redirect2[RS1_BIT]),
        .load_data_i (load_w_data),
        .m_data_i    (fwd_m_data),
        .w_data_i    (fwd_w_data),
        .op_o        (mux1)
    );

    id_ex_pipe_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_addr_i   (rs2_addr_e),
        .raw_i       (rs2_data_e),
        .load_sel_i  (load_redirect[RS2_BIT]),
        .sel1_i      (redirect1[RS2_BIT]),
        .sel2_i      (redirect2[RS2_BIT]),
        .load_data_i (load_w_data),
        .m_data_i    (fwd_m_data),
        .w_data_i    (fwd_w_data),
        .op_o        (mux2)
    );

    // FSM state, operand hold registers and performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            hold_vld_q   <= '0;
            hold_op1_q   <= '0;
            hold_op2_q   <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_vld_q   <= hold_vld_d;
            hold_op1_q   <= hold_op1_d;
            hold_op2_q   <= hold_op2_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Next state: flush returns to RUN; a stall entered from RUN captures the
    // live operands; leaving the stall drops the held values.
    always_comb begin
        state_d      = state_q;
        hold_vld_d   = hold_vld_q;
        hold_op1_d   = hold_op1_q;
        hold_op2_d   = hold_op2_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush_e) begin
            state_d      = RUN;
            hold_vld_d   = '0;
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else if (stall_e) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
            if (state_q == RUN) begin
                hold_op1_d = mux1;
                hold_op2_d = mux2;
                hold_vld_d = 2'b11;
                state_d    = HOLD;
            end
        end else begin
            state_d    = RUN;
            hold_vld_d = '0;
        end
    end

    // Operand select: held value while frozen, unless the load result for
    // that operand has just arrived at WB.
    always_comb begin
        op1_e = mux1;
        op2_e = mux2;
        if (state_q == HOLD) begin
            if (hold_vld_q[RS1_BIT] && !load_redirect[RS1_BIT]) begin
                op1_e = hold_op1_q;
            end
            if (hold_vld_q[RS2_BIT] && !load_redirect[RS2_BIT]) begin
                op2_e = hold_op2_q;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: the stimulus process pushes expected
// output values tagged with the cycle they apply to; the monitor pops and
// compares them on the falling edge.
module tb_id_ex_pipe;

    localparam int XLEN  = 64;
    localparam int PC_W  = 64;
    localparam int OP_W  = 8;
    localparam int CNT_W = 4;

    localparam int S_VALID  = 0;
    localparam int S_PC     = 1;
    localparam int S_OP     = 2;
    localparam int S_IMM    = 3;
    localparam int S_OP1    = 4;
    localparam int S_OP2    = 5;
    localparam int S_RD     = 6;
    localparam int S_WE     = 7;
    localparam int S_LOAD   = 8;
    localparam int S_STALL  = 9;
    localparam int S_BUBBLE = 10;

    typedef struct {
        int unsigned cyc;
        int          sel;
        logic [63:0] val;
        string       name;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid_d;
    logic [PC_W-1:0]  pc_d;
    logic [OP_W-1:0]  op_d;
    logic [XLEN-1:0]  imm_d;
    logic [XLEN-1:0]  rs1_data_d;
    logic [XLEN-1:0]  rs2_data_d;
    logic [4:0]       rs1_addr_d;
    logic [4:0]       rs2_addr_d;
    logic [4:0]       rd_addr_d;
    logic             rd_we_d;
    logic             load_d;
    logic             stall_e;
    logic             flush_e;
    logic [1:0]       redirect1;
    logic [1:0]       redirect2;
    logic [1:0]       load_redirect;
    logic [XLEN-1:0]  fwd_m_data;
    logic [XLEN-1:0]  fwd_w_data;
    logic [XLEN-1:0]  load_w_data;
    logic             valid_e;
    logic [PC_W-1:0]  pc_e;
    logic [OP_W-1:0]  op_e;
    logic [XLEN-1:0]  imm_e;
    logic [XLEN-1:0]  op1_e;
    logic [XLEN-1:0]  op2_e;
    logic [4:0]       rd_addr_e;
    logic             rd_we_e;
    logic             load_e;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        stim_done = 1'b0;

    id_ex_pipe #(
        .XLEN (XLEN), .PC_W (PC_W), .OP_W (OP_W), .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_d       (valid_d),
        .pc_d          (pc_d),
        .op_d          (op_d),
        .imm_d         (imm_d),
        .rs1_data_d    (rs1_data_d),
        .rs2_data_d    (rs2_data_d),
        .rs1_addr_d    (rs1_addr_d),
        .rs2_addr_d    (rs2_addr_d),
        .rd_addr_d     (rd_addr_d),
        .rd_we_d       (rd_we_d),
        .load_d        (load_d),
        .stall_e       (stall_e),
        .flush_e       (flush_e),
        .redirect1     (redirect1),
        .redirect2     (redirect2),
        .load_redirect (load_redirect),
        .fwd_m_data    (fwd_m_data),
        .fwd_w_data    (fwd_w_data),
        .load_w_data   (load_w_data),
        .valid_e       (valid_e),
        .pc_e          (pc_e),
        .op_e          (op_e),
        .imm_e         (imm_e),
        .op1_e         (op1_e),
        .op2_e         (op2_e),
        .rd_addr_e     (rd_addr_e),
        .rd_we_e       (rd_we_e),
        .load_e        (load_e),
        .stall_cnt     (stall_cnt),
        .bubble_cnt    (bubble_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] get_out(input int sel);
        case (sel)
            S_VALID:  return 64'(valid_e);
            S_PC:     return 64'(pc_e);
            S_OP:     return 64'(op_e);
            S_IMM:    return 64'(imm_e);
            S_OP1:    return 64'(op1_e);
            S_OP2:    return 64'(op2_e);
            S_RD:     return 64'(rd_addr_e);
            S_WE:     return 64'(rd_we_e);
            S_LOAD:   return 64'(load_e);
            S_STALL:  return 64'(stall_cnt);
            S_BUBBLE: return 64'(bubble_cnt);
            default:  return 64'hDEAD;
        endcase
    endfunction

    task automatic expect_out(input int sel, input logic [63:0] val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare every scoreboard entry that has come due.
    task automatic check_due();
        exp_t        e;
        logic [63:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = get_out(e.sel);
            n_chk++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", e.name, act, e.val, e.cyc);
            end
        end
    endtask

    // Monitor: owns the counters and the summary line.
    initial begin
        while (!stim_done) begin
            @(negedge clk);
            check_due();
        end
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(negedge clk);
            check_due();
        end
        if (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Stimulus.
    initial begin
        rst_n         = 1'b0;
        valid_d       = 1'b1;
        pc_d          = 64'h1234;
        op_d          = 8'hFF;
        imm_d         = 64'h5A5A;
        rs1_data_d    = 64'h11;
        rs2_data_d    = 64'h22;
        rs1_addr_d    = 5'd1;
        rs2_addr_d    = 5'd2;
        rd_addr_d     = 5'd7;
        rd_we_d       = 1'b1;
        load_d        = 1'b1;
        stall_e       = 1'b1;
        flush_e       = 1'b0;
        redirect1     = 2'b11;
        redirect2     = 2'b11;
        load_redirect = 2'b00;
        fwd_m_data    = 64'hAA;
        fwd_w_data    = 64'hBB;
        load_w_data   = 64'h77;

        // Reset with active inputs.
        step();
        step();
        expect_out(S_VALID, 0, "rst_valid");
        expect_out(S_PC, 0, "rst_pc");
        expect_out(S_RD, 0, "rst_rd");
        expect_out(S_WE, 0, "rst_we");
        expect_out(S_LOAD, 0, "rst_load");
        expect_out(S_OP1, 0, "rst_op1");
        expect_out(S_OP2, 0, "rst_op2");
        expect_out(S_STALL, 0, "rst_stall_cnt");
        expect_out(S_BUBBLE, 0, "rst_bubble_cnt");

        // Plain flow.
        rst_n      = 1'b1;
        stall_e    = 1'b0;
        redirect1  = 2'b00;
        redirect2  = 2'b00;
        load_d     = 1'b0;
        pc_d       = 64'h8000_0000;
        op_d       = 8'h3C;
        imm_d      = 64'h100;
        rd_addr_d  = 5'd5;
        step();
        expect_out(S_VALID, 1, "plain_valid");
        expect_out(S_PC, 64'h8000_0000, "plain_pc");
        expect_out(S_OP, 64'h3C, "plain_op");
        expect_out(S_IMM, 64'h100, "plain_imm");
        expect_out(S_OP1, 64'h11, "plain_op1");
        expect_out(S_OP2, 64'h22, "plain_op2");
        expect_out(S_RD, 5, "plain_rd");
        expect_out(S_WE, 1, "plain_we");
        expect_out(S_LOAD, 0, "plain_load");

        // Forward priority on rs1 = x3.
        rs1_addr_d = 5'd3;
        rs1_data_d = 64'h33;
        step();
        redirect1  = 2'b01;
        redirect2  = 2'b01;
        expect_out(S_OP1, 64'hAA, "fwd_m_over_w");
        step();
        redirect1  = 2'b00;
        expect_out(S_OP1, 64'hBB, "fwd_w_only");
        step();
        redirect1     = 2'b01;
        load_redirect = 2'b01;
        expect_out(S_OP1, 64'h77, "fwd_load_over_all");
        expect_out(S_OP2, 64'h22, "fwd_op2_untouched");
        step();

        // x0 guard.
        redirect1     = 2'b00;
        redirect2     = 2'b00;
        load_redirect = 2'b00;
        rs1_addr_d    = 5'd0;
        rs1_data_d    = 64'h0;
        step();
        redirect1  = 2'b01;
        expect_out(S_OP1, 0, "x0_guard_m");
        step();
        load_redirect = 2'b01;
        expect_out(S_OP1, 0, "x0_guard_load");
        step();

        // Load-use stall.
        redirect1     = 2'b00;
        load_redirect = 2'b00;
        rs1_addr_d    = 5'd3;
        rs1_data_d    = 64'h33;
        step();
        stall_e    = 1'b1;
        redirect2  = 2'b10;
        fwd_w_data = 64'h55;
        pc_d       = 64'h9000;
        expect_out(S_OP2, 64'h55, "stall_entry_op2");
        expect_out(S_OP1, 64'h33, "stall_entry_op1");
        step();
        stall_e       = 1'b0;
        fwd_w_data    = 64'h99;
        load_redirect = 2'b01;
        load_w_data   = 64'h77;
        expect_out(S_OP2, 64'h55, "hold_op2");
        expect_out(S_OP1, 64'h77, "hold_load_override_op1");
        expect_out(S_STALL, 1, "hold_stall_cnt");
        expect_out(S_PC, 64'h8000_0000, "hold_pc");
        step();
        load_redirect = 2'b00;
        expect_out(S_PC, 64'h9000, "after_stall_pc");
        expect_out(S_OP2, 64'h99, "after_stall_op2_live");
        expect_out(S_OP1, 64'h33, "after_stall_op1");

        // Flush beats stall.
        stall_e = 1'b1;
        flush_e = 1'b1;
        step();
        stall_e    = 1'b0;
        flush_e    = 1'b0;
        fwd_w_data = 64'h44;
        expect_out(S_VALID, 0, "flush_valid");
        expect_out(S_RD, 0, "flush_rd");
        expect_out(S_WE, 0, "flush_we");
        expect_out(S_BUBBLE, 1, "flush_bubble_cnt");
        expect_out(S_STALL, 1, "flush_stall_cnt");
        expect_out(S_OP2, 64'h44, "flush_run_live_op2");
        step();

        // Bubble from ID.
        valid_d = 1'b0;
        load_d  = 1'b1;
        step();
        expect_out(S_VALID, 0, "bubble_valid");
        expect_out(S_LOAD, 0, "bubble_load");
        expect_out(S_RD, 0, "bubble_rd");
        valid_d = 1'b1;
        step();
        expect_out(S_VALID, 1, "load_valid");
        expect_out(S_LOAD, 1, "load_flag");
        expect_out(S_BUBBLE, 1, "bubble_cnt_unchanged");
        load_d = 1'b0;

        // Stall counter saturation.
        stall_e = 1'b1;
        for (int i = 0; i < 16; i++) step();
        expect_out(S_STALL, 15, "stall_cnt_saturate");
        step();

        // Asynchronous reset while in HOLD.
        rst_n         = 1'b0;
        load_redirect = 2'b01;
        expect_out(S_VALID, 0, "async_rst_valid");
        expect_out(S_PC, 0, "async_rst_pc");
        expect_out(S_RD, 0, "async_rst_rd");
        expect_out(S_OP1, 0, "async_rst_op1");
        expect_out(S_OP2, 0, "async_rst_op2");
        expect_out(S_STALL, 0, "async_rst_stall_cnt");
        expect_out(S_BUBBLE, 0, "async_rst_bubble_cnt");
        step();
        step();
        stall_e = 1'b0;
        rst_n   = 1'b1;
        step();
        stim_done = 1'b1;
    end

endmodule
